// File: rtl/ram_rw_checker.sv
// Write-then-verify controller for a single-port RAM: fills, reads back, compares, counts mismatches.
// Define RAM_RW_FIRST_FAIL_EN to add fail_addr/fail_data capture of the first mismatch of a run.
module ram_rw_checker #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_en,
    output logic              ram_we,
    output logic              busy,
    output logic              done,
    output logic              pass,
`ifdef RAM_RW_FIRST_FAIL_EN
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
`endif
    output logic [CNT_W-1:0]  err_cnt
);

    typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StDone} state_e;

    localparam logic [ADDR_W-1:0] AddrLast  = '1;
    localparam logic [2:0]        DrainLast = 3'(RD_LAT - 1);
    localparam logic [CNT_W-1:0]  CntMax    = '1;

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        drain_q, drain_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              en_q, en_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic              accept;

    logic [DATA_W-1:0] exp_pipe [RD_LAT];
    logic [RD_LAT-1:0] val_pipe;
    logic              cmp_valid;
    logic              mismatch;

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] inc;
        logic [DATA_W-1:0] chk;
        inc = DATA_W'(a);
        // Even bits set for even addresses (0x55..), odd bits for odd addresses (0xAA..).
        for (int i = 0; i < int'(DATA_W); i++) begin
            chk[i] = (i % 2 == 0) ? ~a[0] : a[0];
        end
        case (m)
            2'b00:   return inc;
            2'b01:   return ~inc;
            2'b10:   return chk;
            default: return '0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        pass_d  = pass_q;
        err_d   = err_q;
        accept  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    accept  = 1'b1;
                    mode_d  = mode;
                    addr_d  = '0;
                    pass_d  = 1'b0;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (addr_q == AddrLast) begin
                    addr_d  = '0;
                    state_d = StRead;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            StRead: begin
                if (addr_q == AddrLast) begin
                    addr_d  = '0;
                    drain_d = '0;
                    state_d = StDrain;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            StDrain: begin
                if (drain_q == DrainLast) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            StDone: begin
                // The last compare lands in the final drain cycle, so err_q is final here.
                pass_d  = (err_q == '0);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            err_d = '0;
        end else if (cmp_valid && mismatch && (err_q != CntMax)) begin
            err_d = err_q + 1'b1;
        end

        en_d      = (state_d == StWrite) || (state_d == StRead);
        we_d      = (state_d == StWrite);
        wr_data_d = we_d ? pattern(mode_d, addr_d) : '0;
        busy_d    = (state_d != StIdle);
        done_d    = (state_d == StDone);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= StIdle;
            mode_q    <= 2'b00;
            addr_q    <= '0;
            drain_q   <= '0;
            wr_data_q <= '0;
            en_q      <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            addr_q    <= addr_d;
            drain_q   <= drain_d;
            wr_data_q <= wr_data_d;
            en_q      <= en_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
        end
    end

    // Expected word and valid travel alongside the RAM read latency.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            val_pipe <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                exp_pipe[i] <= '0;
            end
        end else begin
            val_pipe[0] <= (state_q == StRead);
            exp_pipe[0] <= pattern(mode_q, addr_q);
            for (int i = 1; i < int'(RD_LAT); i++) begin
                val_pipe[i] <= val_pipe[i-1];
                exp_pipe[i] <= exp_pipe[i-1];
            end
        end
    end

    assign cmp_valid = val_pipe[RD_LAT-1];
    assign mismatch  = (ram_rd_data != exp_pipe[RD_LAT-1]);

`ifdef RAM_RW_FIRST_FAIL_EN
    logic [ADDR_W-1:0] addr_pipe [RD_LAT];
    logic              fail_seen_q;
    logic [ADDR_W-1:0] fail_addr_q;
    logic [DATA_W-1:0] fail_data_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < int'(RD_LAT); i++) begin
                addr_pipe[i] <= '0;
            end
            fail_seen_q <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            addr_pipe[0] <= addr_q;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                addr_pipe[i] <= addr_pipe[i-1];
            end
            if (accept) begin
                fail_seen_q <= 1'b0;
                fail_addr_q <= '0;
                fail_data_q <= '0;
            end else if (cmp_valid && mismatch && !fail_seen_q) begin
                fail_seen_q <= 1'b1;
                fail_addr_q <= addr_pipe[RD_LAT-1];
                fail_data_q <= ram_rd_data;
            end
        end
    end

    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
`endif

    assign ram_wr_data = wr_data_q;
    assign ram_addr    = addr_q;
    assign ram_en      = en_q;
    assign ram_we      = we_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign err_cnt     = err_q;

endmodule

// File: tb/tb_ram_rw_checker.sv
// Self-checking bench for ram_rw_checker: three parameterisations, RAM models and a write/read scoreboard.
module tb_ram_rw_checker;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int pat(input int m, input int a, input int dw);
        int mask;
        mask = (1 << dw) - 1;
        case (m)
            0:       return a & mask;
            1:       return ~a & mask;
            2:       return (((a % 2) != 0) ? 32'hAAAA_AAAA : 32'h5555_5555) & mask;
            default: return 0;
        endcase
    endfunction

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t wq_a[$];
    int  rq_a[$];
    wr_t wq_b[$];
    int  rq_b[$];

    // DUT A: defaults, ideal RAM with optional bit-0 flip at address 7.
    logic        a_start, a_en, a_we, a_busy, a_done, a_pass, a_flip;
    logic [1:0]  a_mode;
    logic [7:0]  a_rd, a_wr;
    logic [4:0]  a_addr;
    logic [15:0] a_err;
    logic [7:0]  mem_a [32];
`ifdef RAM_RW_FIRST_FAIL_EN
    logic [4:0]  a_fail_addr;
    logic [7:0]  a_fail_data;
`endif

    ram_rw_checker dut_a (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .start       (a_start),
        .mode        (a_mode),
        .ram_rd_data (a_rd),
        .ram_wr_data (a_wr),
        .ram_addr    (a_addr),
        .ram_en      (a_en),
        .ram_we      (a_we),
        .busy        (a_busy),
        .done        (a_done),
        .pass        (a_pass),
`ifdef RAM_RW_FIRST_FAIL_EN
        .fail_addr   (a_fail_addr),
        .fail_data   (a_fail_data),
`endif
        .err_cnt     (a_err)
    );

    always @(posedge sys_clk) begin
        if (a_en && a_we) mem_a[a_addr] <= a_wr;
        if (a_en && !a_we) a_rd <= mem_a[a_addr] ^ ((a_flip && a_addr == 5'd7) ? 8'h01 : 8'h00);
    end

    // DUT B: 16-bit data, 16 words, three-cycle read latency.
    logic        b_start, b_en, b_we, b_busy, b_done, b_pass;
    logic [1:0]  b_mode;
    logic [15:0] b_rd, b_wr, b_p1, b_p2;
    logic [3:0]  b_addr;
    logic [15:0] b_err;
    logic [15:0] mem_b [16];
`ifdef RAM_RW_FIRST_FAIL_EN
    logic [3:0]  b_fail_addr;
    logic [15:0] b_fail_data;
`endif

    ram_rw_checker #(.DATA_W(16), .ADDR_W(4), .RD_LAT(3), .CNT_W(16)) dut_b (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .start       (b_start),
        .mode        (b_mode),
        .ram_rd_data (b_rd),
        .ram_wr_data (b_wr),
        .ram_addr    (b_addr),
        .ram_en      (b_en),
        .ram_we      (b_we),
        .busy        (b_busy),
        .done        (b_done),
        .pass        (b_pass),
`ifdef RAM_RW_FIRST_FAIL_EN
        .fail_addr   (b_fail_addr),
        .fail_data   (b_fail_data),
`endif
        .err_cnt     (b_err)
    );

    always @(posedge sys_clk) begin
        if (b_en && b_we) mem_b[b_addr] <= b_wr;
        b_p1 <= mem_b[b_addr];
        b_p2 <= b_p1;
        b_rd <= b_p2;
    end

    // DUT C: 4-bit error counter against a RAM stuck at 0xFF.
    logic        c_start, c_en, c_we, c_busy, c_done, c_pass;
    logic [1:0]  c_mode;
    logic [7:0]  c_rd, c_wr;
    logic [4:0]  c_addr;
    logic [3:0]  c_err;
`ifdef RAM_RW_FIRST_FAIL_EN
    logic [4:0]  c_fail_addr;
    logic [7:0]  c_fail_data;
`endif
    assign c_rd = 8'hFF;

    ram_rw_checker #(.CNT_W(4)) dut_c (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .start       (c_start),
        .mode        (c_mode),
        .ram_rd_data (c_rd),
        .ram_wr_data (c_wr),
        .ram_addr    (c_addr),
        .ram_en      (c_en),
        .ram_we      (c_we),
        .busy        (c_busy),
        .done        (c_done),
        .pass        (c_pass),
`ifdef RAM_RW_FIRST_FAIL_EN
        .fail_addr   (c_fail_addr),
        .fail_data   (c_fail_data),
`endif
        .err_cnt     (c_err)
    );

    // Scoreboard: every RAM access must match the next queued expectation.
    wr_t mon_a_w, mon_b_w;
    int  mon_a_r, mon_b_r;

    always @(negedge sys_clk) begin
        if (sys_rst_n && a_en) begin
            if (a_we) begin
                if (wq_a.size() == 0) check_val("a_wr_unexpected", 1, 0);
                else begin
                    mon_a_w = wq_a.pop_front();
                    check_val("a_wr_addr", a_addr, mon_a_w.addr);
                    check_val("a_wr_data", a_wr, mon_a_w.data);
                end
            end else begin
                check_val("a_rd_wdata_zero", a_wr, 0);
                if (rq_a.size() == 0) check_val("a_rd_unexpected", 1, 0);
                else begin
                    mon_a_r = rq_a.pop_front();
                    check_val("a_rd_addr", a_addr, mon_a_r);
                end
            end
        end
        if (sys_rst_n && b_en) begin
            if (b_we) begin
                if (wq_b.size() == 0) check_val("b_wr_unexpected", 1, 0);
                else begin
                    mon_b_w = wq_b.pop_front();
                    check_val("b_wr_addr", b_addr, mon_b_w.addr);
                    check_val("b_wr_data", b_wr, mon_b_w.data);
                end
            end else begin
                if (rq_b.size() == 0) check_val("b_rd_unexpected", 1, 0);
                else begin
                    mon_b_r = rq_b.pop_front();
                    check_val("b_rd_addr", b_addr, mon_b_r);
                end
            end
        end
    end

    task automatic push_a(input int m);
        wr_t w;
        for (int a = 0; a < 32; a++) begin
            w.addr = a;
            w.data = pat(m, a, 8);
            wq_a.push_back(w);
            rq_a.push_back(a);
        end
    endtask

    task automatic run_a(input logic [1:0] m, input logic flip, input int exp_err, input bit repulse);
        int done_cyc = 0;
        int n_done = 0;
        push_a(int'(m));
        a_flip = flip;
        @(negedge sys_clk);
        a_mode  = m;
        a_start = 1'b1;
        @(negedge sys_clk);
        a_start = 1'b0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            if (cyc == 1) begin
                check_val("a_busy_first", a_busy, 1);
                check_val("a_err_cleared", a_err, 0);
            end
            if (cyc == 66) check_val("a_busy_last", a_busy, 1);
            if (cyc == 67) begin
                check_val("a_busy_after", a_busy, 0);
                check_val("a_pass", a_pass, (exp_err == 0) ? 1 : 0);
            end
            if (repulse) a_start = (cyc == 10);
            if (a_done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            @(negedge sys_clk);
        end
        check_val("a_done_cycle", done_cyc, 66);
        check_val("a_done_count", n_done, 1);
        check_val("a_err_cnt", a_err, exp_err);
        check_val("a_pass_hold", a_pass, (exp_err == 0) ? 1 : 0);
        check_val("a_wq_empty", wq_a.size(), 0);
        check_val("a_rq_empty", rq_a.size(), 0);
`ifdef RAM_RW_FIRST_FAIL_EN
        check_val("a_fail_addr", a_fail_addr, flip ? 7 : 0);
        check_val("a_fail_data", a_fail_data, flip ? 32'hF9 : 0);
`endif
    endtask

    task automatic run_b();
        int done_cyc = 0;
        int n_done = 0;
        wr_t w;
        for (int a = 0; a < 16; a++) begin
            w.addr = a;
            w.data = pat(2, a, 16);
            wq_b.push_back(w);
            rq_b.push_back(a);
        end
        @(negedge sys_clk);
        b_mode  = 2'b10;
        b_start = 1'b1;
        @(negedge sys_clk);
        b_start = 1'b0;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            if (b_done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (cyc == 37) check_val("b_pass", b_pass, 1);
            @(negedge sys_clk);
        end
        check_val("b_done_cycle", done_cyc, 36);
        check_val("b_done_count", n_done, 1);
        check_val("b_err_cnt", b_err, 0);
        check_val("b_busy_end", b_busy, 0);
        check_val("b_wq_empty", wq_b.size(), 0);
        check_val("b_rq_empty", rq_b.size(), 0);
    endtask

    task automatic run_c();
        int done_cyc = 0;
        @(negedge sys_clk);
        c_mode  = 2'b11;
        c_start = 1'b1;
        @(negedge sys_clk);
        c_start = 1'b0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            if (c_done && done_cyc == 0) done_cyc = cyc;
            if (c_en && c_we && cyc == 5) check_val("c_wr_zero", c_wr, 0);
            @(negedge sys_clk);
        end
        check_val("c_done_cycle", done_cyc, 66);
        check_val("c_err_sat", c_err, 15);
        check_val("c_pass", c_pass, 0);
    endtask

    task automatic reset_abort();
        push_a(0);
        @(negedge sys_clk);
        a_mode  = 2'b00;
        a_start = 1'b1;
        @(negedge sys_clk);
        a_start = 1'b0;
        repeat (19) @(negedge sys_clk);
        check_val("rst_pre_addr", a_addr, 19);
        sys_rst_n = 1'b0;
        #1;
        check_val("rst_en", a_en, 0);
        check_val("rst_we", a_we, 0);
        check_val("rst_addr", a_addr, 0);
        check_val("rst_busy", a_busy, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            check_val("rst_no_done", a_done, 0);
        end
        sys_rst_n = 1'b1;
        wq_a.delete();
        rq_a.delete();
        for (int i = 0; i < 70; i++) begin
            @(negedge sys_clk);
            if (a_done) check_val("rst_late_done", a_done, 0);
        end
    endtask

    task automatic back_to_back();
        int  n_done = 0;
        int  done_cyc[2];
        bit  prev_done = 1'b0;
        bit  prev2 = 1'b0;
        push_a(1);
        push_a(1);
        a_flip = 1'b1;
        done_cyc[0] = 0;
        done_cyc[1] = 0;
        @(negedge sys_clk);
        a_mode  = 2'b01;
        a_start = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge sys_clk);
            if (prev2) begin
                check_val("b2b_restart_busy", a_busy, 1);
                check_val("b2b_err_clear", a_err, 0);
            end
            prev2 = prev_done && (n_done < 2);
            if (prev_done) begin
                check_val("b2b_idle", a_busy, 0);
                if (n_done == 2) a_start = 1'b0;
            end
            if (a_done) begin
                if (n_done < 2) done_cyc[n_done] = cyc;
                n_done++;
                check_val("b2b_err_done", a_err, 1);
            end
            prev_done = a_done;
        end
        a_start = 1'b0;
        check_val("b2b_done_count", n_done, 2);
        check_val("b2b_done0", done_cyc[0], 66);
        check_val("b2b_done1", done_cyc[1], 133);
        check_val("b2b_wq_empty", wq_a.size(), 0);
        check_val("b2b_rq_empty", rq_a.size(), 0);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        a_start = 1'b0; a_mode = 2'b00; a_flip = 1'b0;
        b_start = 1'b0; b_mode = 2'b00;
        c_start = 1'b0; c_mode = 2'b00;
        repeat (3) @(negedge sys_clk);
        check_val("reset_en", a_en, 0);
        check_val("reset_we", a_we, 0);
        check_val("reset_addr", a_addr, 0);
        check_val("reset_wdata", a_wr, 0);
        check_val("reset_busy", a_busy, 0);
        check_val("reset_done", a_done, 0);
        check_val("reset_pass", a_pass, 0);
        check_val("reset_err", a_err, 0);
        sys_rst_n = 1'b1;

        run_a(2'b00, 1'b0, 0, 1'b0);
        run_a(2'b01, 1'b1, 1, 1'b0);
        run_a(2'b00, 1'b0, 0, 1'b1);
        run_b();
        run_c();
        reset_abort();
        run_a(2'b00, 1'b0, 0, 1'b0);
        back_to_back();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_rw_checker.md
Name: ram_rw_checker

Overview:
- Parametrised write-then-verify controller for a single-port RAM (one shared address bus, en/we strobes).
- Per run: fills every address with a selectable data pattern, reads every address back, and compares each word against the expected value.
- Reports pass/fail and a saturating mismatch count.
- Sits between a single-port block RAM instance and board-level status logic (LEDs / ILA).

Parameters:
- DATA_W, 8: RAM data width in bits (>=2).
- ADDR_W, 5: RAM address width. DEPTH = 2**ADDR_W words.
- RD_LAT, 1: RAM read latency in clocks, from address presented to ram_rd_data valid (1..4).
- CNT_W, 16: width of err_cnt.

Ports:
- sys_clk  in  1  system clock, all logic on rising edge
- sys_rst_n  in  1  asynchronous active-low reset
- start  in  1  run request, sampled only in IDLE
- mode  in  2  pattern select, latched on accepted start
- ram_rd_data  in  DATA_W  RAM read data
- ram_wr_data  out  DATA_W  RAM write data
- ram_addr  out  ADDR_W  RAM address
- ram_en  out  1  RAM enable, active high
- ram_we  out  1  RAM write enable, active high
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- pass  out  1  result of last run: 1 = zero mismatches
- err_cnt  out  CNT_W  mismatch count of current/last run, saturating

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- Reset is asynchronous. Reset mid-run aborts immediately: en/we drop, counters clear, no done pulse.
- All RAM-side outputs are registered.
- Pattern p(a) for address a, selected by the latched mode:
  - 00: a, zero-extended/truncated to DATA_W.
  - 01: bitwise inverse of the mode-00 value.
  - 10: checkerboard. 0x55.. when a[0]=0, 0xAA.. when a[0]=1, sized to DATA_W.
  - 11: all zeros.
- FSM states:
  - IDLE: en=0, we=0, addr=0. On start=1: latch mode, clear err_cnt and pass, busy<=1, go to WRITE.
  - WRITE: en=1, we=1, addr steps 0..DEPTH-1 one per clock, wr_data=p(addr) on the same cycle. After addr DEPTH-1 is written, go to READ with addr=0.
  - READ: en=1, we=0, wr_data=0, addr steps 0..DEPTH-1. After the last address, go to DRAIN.
  - DRAIN: en=0, we=0. Hold RD_LAT cycles, then go to DONE.
  - DONE: done=1 for exactly one cycle; pass<=(err_cnt==0), evaluated after the final compare; busy<=0; go to IDLE.
- Compare pipeline: expected word and a valid flag are delayed RD_LAT stages from the read-address cycle. When the delayed valid is set and ram_rd_data differs from the delayed expected word, err_cnt increments. err_cnt holds at all-ones (no wrap).
- Timing: with start sampled at edge 0, WRITE occupies cycles 1..DEPTH, READ occupies DEPTH+1..2*DEPTH, and done is high in cycle 2*DEPTH+RD_LAT+1. busy is high in cycles 1 through 2*DEPTH+RD_LAT+1 inclusive.
- start while busy is ignored and not queued. start held high continuously restarts a new run on the first IDLE cycle after DONE.
- Address wrap: the address counter never wraps inside a phase. The phase transition resets it to 0.
- pass and err_cnt hold their values until the next accepted start.

Optional Feature:
- Macro: RAM_RW_FIRST_FAIL_EN.
- Defined:
  - Adds ports fail_addr (out, ADDR_W) and fail_data (out, DATA_W), both reset to 0 and cleared on accepted start.
  - On the first mismatch of a run, they capture the delayed read address and the ram_rd_data value, then hold until the next start.
  - Later mismatches do not overwrite them.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Defaults, mode=00, ideal RAM model with RD_LAT=1, pulse start -> 32 writes with wr_data=addr 0..31, 32 reads; done in cycle 66 after start; pass=1; err_cnt=0.
- mode=01, model forces bit 0 of the word at addr 7 to flip on readback -> err_cnt=1, pass=0. With RAM_RW_FIRST_FAIL_EN: fail_addr=7, fail_data=0xF9 (expected 0xF8 XOR 0x01).
- RD_LAT=3, DATA_W=16, ADDR_W=4, mode=10 -> writes alternate 0x5555/0xAAAA; done in cycle 36; pass=1. Compare aligned: no false mismatches at phase edges.
- CNT_W=4, model returns constant 0xFF, mode=11, 32 words -> err_cnt saturates at 15, pass=0.
- Assert sys_rst_n low in cycle 20 of WRITE -> en/we/addr/busy go to 0 immediately, no done; a subsequent start runs a full clean pass.
- start pulsed again in cycle 10 of a run -> ignored, single done pulse. start held high -> back-to-back runs, each preceded by exactly one IDLE cycle, each starting with err_cnt=0.
